// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_pkg;

  localparam int unsigned DMEM_WORDS_DEFAULT = 1024;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } req_id_e;

  // Expand byte enables into a bit mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin arbiter: on a tie, grants the requester that was not accepted last.
module dmem_rr_arb
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_valid,
  input  logic       i_enable,
  input  logic       i_accept,
  output logic [1:0] o_grant,
  output req_id_e    o_rr_last
);

  req_id_e r_rr_last;

  always_comb begin
    o_grant = 2'b00;
    if (i_enable) begin
      if (&i_valid) begin
        o_grant = (r_rr_last == REQ_DBG) ? 2'b01 : 2'b10;
      end else begin
        o_grant = i_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr_last <= REQ_DBG;
    end else if (i_accept) begin
      r_rr_last <= o_grant[1] ? REQ_DBG : REQ_CORE;
    end
  end

  assign o_rr_last = r_rr_last;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port word memory between core and debug requesters; partial stores
// are done as read-modify-write over two cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_req_valid,
  output logic        core_req_ready,
  input  logic        core_req_write,
  input  logic [31:0] core_req_addr,
  input  logic [31:0] core_req_wdata,
  input  logic [3:0]  core_req_be,
  output logic        core_resp_valid,
  output logic [31:0] core_resp_rdata,
  output logic        core_resp_err,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic        dbg_req_write,
  input  logic [31:0] dbg_req_addr,
  input  logic [31:0] dbg_req_wdata,
  input  logic [3:0]  dbg_req_be,
  output logic        dbg_resp_valid,
  output logic [31:0] dbg_resp_rdata,
  output logic        dbg_resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned WIDX_W = $clog2(DMEM_WORDS);

  state_e            r_state;
  logic [WIDX_W-1:0] r_widx;
  logic [31:0]       r_merged;
  req_id_e           r_owner;
  logic              r_core_resp_valid, r_dbg_resp_valid;
  logic              r_core_resp_err, r_dbg_resp_err;
  logic [31:0]       r_core_resp_rdata, r_dbg_resp_rdata;

  logic [1:0]        w_grant;
  req_id_e           w_rr_last_unused;
  logic              w_enable, w_accept, w_sel_dbg;
  logic              w_write;
  logic [31:0]       w_addr, w_wdata, w_mask, w_merged, w_load_data;
  logic [3:0]        w_be;
  logic [29:0]       w_widx_full;
  logic [WIDX_W-1:0] w_widx;
  logic              w_oor, w_be_full, w_partial, w_mem_ok;
  logic              w_addr_lsb_unused;

  assign w_enable = reset_n & (r_state == IDLE);

  dmem_rr_arb u_rr_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_valid   ({dbg_req_valid, core_req_valid}),
    .i_enable  (w_enable),
    .i_accept  (w_accept),
    .o_grant   (w_grant),
    .o_rr_last (w_rr_last_unused)
  );

  assign core_req_ready = core_req_valid & w_grant[0];
  assign dbg_req_ready  = dbg_req_valid & w_grant[1];
  assign w_accept       = core_req_ready | dbg_req_ready;
  assign w_sel_dbg      = w_grant[1];

  assign w_write = w_sel_dbg ? dbg_req_write : core_req_write;
  assign w_addr  = w_sel_dbg ? dbg_req_addr  : core_req_addr;
  assign w_wdata = w_sel_dbg ? dbg_req_wdata : core_req_wdata;
  assign w_be    = w_sel_dbg ? dbg_req_be    : core_req_be;

  assign w_addr_lsb_unused = ^w_addr[1:0];
  assign w_widx_full = w_addr[31:2];
  assign w_widx      = w_widx_full[WIDX_W-1:0];
  assign w_oor       = (w_widx_full >= 30'(DMEM_WORDS));
  assign w_be_full   = &w_be;
  assign w_partial   = w_write & ~w_be_full & (|w_be);
  assign w_mem_ok    = w_accept & ~w_oor;

  assign w_mask      = be_to_mask(w_be);
  assign w_merged    = (mem_read_data & ~w_mask) | (w_wdata & w_mask);
  assign w_load_data = (!w_write && !w_oor) ? mem_read_data : 32'h0;

  // Memory port: RMW write phase owns the port; otherwise driven by the accepted request.
  always_comb begin
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_addr         = 32'h0;
    mem_write_data   = 32'h0;
    if (reset_n) begin
      if (r_state == RMW_WR) begin
        mem_write_enable = 1'b1;
        mem_addr         = 32'(r_widx);
        mem_write_data   = r_merged;
      end else if (w_mem_ok) begin
        if (!w_write || w_partial) begin
          mem_read_enable = 1'b1;
          mem_addr        = 32'(w_widx);
        end else if (w_be_full) begin
          mem_write_enable = 1'b1;
          mem_addr         = 32'(w_widx);
          mem_write_data   = w_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state           <= IDLE;
      r_widx            <= '0;
      r_merged          <= 32'h0;
      r_owner           <= REQ_CORE;
      r_core_resp_valid <= 1'b0;
      r_dbg_resp_valid  <= 1'b0;
      r_core_resp_err   <= 1'b0;
      r_dbg_resp_err    <= 1'b0;
      r_core_resp_rdata <= 32'h0;
      r_dbg_resp_rdata  <= 32'h0;
    end else begin
      r_core_resp_valid <= 1'b0;
      r_dbg_resp_valid  <= 1'b0;
      r_core_resp_err   <= 1'b0;
      r_dbg_resp_err    <= 1'b0;
      r_core_resp_rdata <= 32'h0;
      r_dbg_resp_rdata  <= 32'h0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_partial && !w_oor) begin
              r_state  <= RMW_WR;
              r_widx   <= w_widx;
              r_merged <= w_merged;
              r_owner  <= w_sel_dbg ? REQ_DBG : REQ_CORE;
            end else if (w_sel_dbg) begin
              r_dbg_resp_valid <= 1'b1;
              r_dbg_resp_err   <= w_oor;
              r_dbg_resp_rdata <= w_load_data;
            end else begin
              r_core_resp_valid <= 1'b1;
              r_core_resp_err   <= w_oor;
              r_core_resp_rdata <= w_load_data;
            end
          end
        end
        RMW_WR: begin
          r_state <= IDLE;
          if (r_owner == REQ_DBG) begin
            r_dbg_resp_valid <= 1'b1;
          end else begin
            r_core_resp_valid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign core_resp_valid = r_core_resp_valid;
  assign core_resp_err   = r_core_resp_err;
  assign core_resp_rdata = r_core_resp_rdata;
  assign dbg_resp_valid  = r_dbg_resp_valid;
  assign dbg_resp_err    = r_dbg_resp_err;
  assign dbg_resp_rdata  = r_dbg_resp_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a word-array model.
module tb_dmem_arbiter;

  localparam int unsigned WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_req_valid, core_req_ready, core_req_write;
  logic [31:0] core_req_addr, core_req_wdata;
  logic [3:0]  core_req_be;
  logic        core_resp_valid, core_resp_err;
  logic [31:0] core_resp_rdata;
  logic        dbg_req_valid, dbg_req_ready, dbg_req_write;
  logic [31:0] dbg_req_addr, dbg_req_wdata;
  logic [3:0]  dbg_req_be;
  logic        dbg_resp_valid, dbg_resp_err;
  logic [31:0] dbg_resp_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_read_enable, mem_write_enable;

  always #5 clk = ~clk;

  dmem_arbiter #(.DMEM_WORDS(WORDS)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .core_req_valid   (core_req_valid),
    .core_req_ready   (core_req_ready),
    .core_req_write   (core_req_write),
    .core_req_addr    (core_req_addr),
    .core_req_wdata   (core_req_wdata),
    .core_req_be      (core_req_be),
    .core_resp_valid  (core_resp_valid),
    .core_resp_rdata  (core_resp_rdata),
    .core_resp_err    (core_resp_err),
    .dbg_req_valid    (dbg_req_valid),
    .dbg_req_ready    (dbg_req_ready),
    .dbg_req_write    (dbg_req_write),
    .dbg_req_addr     (dbg_req_addr),
    .dbg_req_wdata    (dbg_req_wdata),
    .dbg_req_be       (dbg_req_be),
    .dbg_resp_valid   (dbg_resp_valid),
    .dbg_resp_rdata   (dbg_resp_rdata),
    .dbg_resp_err     (dbg_resp_err),
    .mem_addr         (mem_addr),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  // Attached data memory: combinational read, clocked write.
  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];
  assign mem_read_data = (mem_addr < WORDS) ? mem[mem_addr[9:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_write_enable && mem_addr < WORDS) mem[mem_addr[9:0]] <= mem_write_data;
  end

  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  bit          rand_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    int unsigned due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  req_t core_src[$];
  req_t dbg_src[$];
  exp_t exp_core[$];
  exp_t exp_dbg[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, want);
    end
  endtask

  function automatic req_t rand_req();
    req_t        r;
    logic [31:0] widx;
    case ($urandom_range(0, 9))
      0:       widx = $urandom_range(1024, 32'h3FFF_FFFF);
      1:       widx = 32'd1023;
      default: widx = $urandom_range(0, 15);
    endcase
    r.wr    = 1'($urandom_range(0, 1));
    r.addr  = {widx[29:0], 2'($urandom)};
    r.wdata = $urandom;
    case ($urandom_range(0, 3))
      0:       r.be = 4'hF;
      1:       r.be = 4'h0;
      default: r.be = 4'($urandom);
    endcase
    return r;
  endfunction

  task automatic push(input int p, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    req_t r;
    r = '{wr: wr, addr: addr, wdata: wdata, be: be};
    if (p == 0) core_src.push_back(r);
    else dbg_src.push_back(r);
  endtask

  // Driver: holds a request until accepted, then takes the next one.
  task automatic drive(input int p, input bit acc);
    req_t r;
    bit   have;
    r    = '0;
    have = 1'b0;
    if (p == 0 && core_req_valid && !acc) return;
    if (p == 1 && dbg_req_valid && !acc) return;
    if (p == 0 && core_src.size() > 0) begin
      r = core_src.pop_front();
      have = 1'b1;
    end else if (p == 1 && dbg_src.size() > 0) begin
      r = dbg_src.pop_front();
      have = 1'b1;
    end else if (rand_en && $urandom_range(0, 3) != 0) begin
      r = rand_req();
      have = 1'b1;
    end
    if (p == 0) begin
      core_req_valid = have;
      core_req_write = r.wr;
      core_req_addr  = r.addr;
      core_req_wdata = r.wdata;
      core_req_be    = r.be;
    end else begin
      dbg_req_valid = have;
      dbg_req_write = r.wr;
      dbg_req_addr  = r.addr;
      dbg_req_wdata = r.wdata;
      dbg_req_be    = r.be;
    end
  endtask

  initial begin
    bit ca, da;
    core_req_valid = 1'b0; core_req_write = 1'b0; core_req_addr = '0;
    core_req_wdata = '0;   core_req_be = '0;
    dbg_req_valid = 1'b0;  dbg_req_write = 1'b0;  dbg_req_addr = '0;
    dbg_req_wdata = '0;    dbg_req_be = '0;
    forever begin
      @(negedge clk);
      ca = core_req_valid & core_req_ready;
      da = dbg_req_valid & dbg_req_ready;
      @(posedge clk);
      #1;
      drive(0, ca);
      drive(1, da);
    end
  end

  // Reference model: decides grants, memory activity and responses from the rules alone.
  initial begin
    bit          busy;
    int          rr, g;
    logic [9:0]  pend_widx;
    logic [31:0] pend_merged;
    logic        exp_re, exp_we, exp_rc, exp_rd;
    logic [31:0] exp_addr, exp_wd;
    logic        wr;
    logic [31:0] addr, wdata, widx, m;
    logic [3:0]  be;
    exp_t        e;
    busy = 1'b0;
    rr   = 1;
    pend_widx   = '0;
    pend_merged = '0;
    forever begin
      @(negedge clk);
      exp_re = 1'b0; exp_we = 1'b0; exp_rc = 1'b0; exp_rd = 1'b0;
      exp_addr = 32'h0; exp_wd = 32'h0;
      if (!reset_n) begin
        busy = 1'b0;
        rr   = 1;
        while (exp_core.size() > 0 && exp_core[$].due > cyc) void'(exp_core.pop_back());
        while (exp_dbg.size() > 0 && exp_dbg[$].due > cyc) void'(exp_dbg.pop_back());
      end else if (busy) begin
        exp_we   = 1'b1;
        exp_addr = 32'(pend_widx);
        exp_wd   = pend_merged;
        ref_mem[pend_widx] = pend_merged;
        busy = 1'b0;
      end else begin
        g = -1;
        if (core_req_valid && dbg_req_valid) g = (rr == 1) ? 0 : 1;
        else if (core_req_valid) g = 0;
        else if (dbg_req_valid) g = 1;
        if (g >= 0) begin
          wr    = (g == 0) ? core_req_write : dbg_req_write;
          addr  = (g == 0) ? core_req_addr  : dbg_req_addr;
          wdata = (g == 0) ? core_req_wdata : dbg_req_wdata;
          be    = (g == 0) ? core_req_be    : dbg_req_be;
          widx  = addr >> 2;
          e.due = cyc + 1;
          e.err = 1'b0;
          e.rdata = 32'h0;
          if (widx >= WORDS) begin
            e.err = 1'b1;
          end else if (!wr) begin
            exp_re   = 1'b1;
            exp_addr = widx;
            e.rdata  = ref_mem[widx[9:0]];
          end else if (be == 4'hF) begin
            exp_we   = 1'b1;
            exp_addr = widx;
            exp_wd   = wdata;
            ref_mem[widx[9:0]] = wdata;
          end else if (be != 4'h0) begin
            exp_re   = 1'b1;
            exp_addr = widx;
            m = ref_mem[widx[9:0]];
            for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = wdata[8*b +: 8];
            pend_widx   = widx[9:0];
            pend_merged = m;
            busy  = 1'b1;
            e.due = cyc + 2;
          end
          if (g == 0) begin
            exp_core.push_back(e);
            exp_rc = 1'b1;
          end else begin
            exp_dbg.push_back(e);
            exp_rd = 1'b1;
          end
          rr = g;
        end
      end
      check("ready", 128'({core_req_ready, dbg_req_ready}), 128'({exp_rc, exp_rd}));
      check("memif", 128'({mem_read_enable, mem_write_enable, mem_addr, mem_write_data}),
            128'({exp_re, exp_we, exp_addr, exp_wd}));
    end
  end

  // Response monitor: pops the owner's scoreboard whenever a response appears.
  task automatic mon(input int p);
    logic        v, err;
    logic [31:0] rd;
    bit          have;
    exp_t        e;
    string       nm;
    nm   = (p == 0) ? "core" : "dbg";
    v    = (p == 0) ? core_resp_valid : dbg_resp_valid;
    err  = (p == 0) ? core_resp_err   : dbg_resp_err;
    rd   = (p == 0) ? core_resp_rdata : dbg_resp_rdata;
    have = (p == 0) ? (exp_core.size() > 0) : (exp_dbg.size() > 0);
    e    = '{due: 0, err: 1'b0, rdata: 32'h0};
    if (have) e = (p == 0) ? exp_core[0] : exp_dbg[0];
    if (v) begin
      if (!have) begin
        check({nm, "_resp_unexpected"}, 128'(v), 128'(0));
      end else begin
        if (p == 0) void'(exp_core.pop_front());
        else void'(exp_dbg.pop_front());
        check({nm, "_resp_cycle"}, 128'(cyc), 128'(e.due));
        check({nm, "_resp_data"}, 128'({err, rd}), 128'({e.err, e.rdata}));
      end
    end else if (have && e.due <= cyc) begin
      if (p == 0) void'(exp_core.pop_front());
      else void'(exp_dbg.pop_front());
      check({nm, "_resp_missing"}, 128'(v), 128'(1));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0);
      mon(1);
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      #2;
      if (core_src.size() == 0 && dbg_src.size() == 0 && !core_req_valid && !dbg_req_valid &&
          exp_core.size() == 0 && exp_dbg.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", 128'(ok), 128'(1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    bit          got;
    int unsigned nmis;
    for (int i = 0; i < WORDS; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp", 128'({core_resp_valid, dbg_resp_valid, core_resp_err, dbg_resp_err,
                            core_resp_rdata, dbg_resp_rdata}), 128'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Full store then load on core.
    push(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    push(0, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_idle();

    // Partial store on dbg, then read back the merged word.
    push(1, 1'b1, 32'h11, 32'h0000_AB00, 4'b0010);
    push(1, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_idle();

    // Continuous loads from both ports after reset alternate grants.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push(0, 1'b0, 32'(4 * i), 32'h0, 4'h0);
      push(1, 1'b0, 32'h10, 32'h0, 4'h0);
    end
    wait_idle();

    // Out-of-range accesses.
    push(0, 1'b0, 32'h1000, 32'h0, 4'h0);
    push(0, 1'b1, 32'h2000, 32'h1234_5678, 4'hF);
    push(0, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_idle();

    // Reset lands on the write phase of a partial store.
    push(0, 1'b1, 32'h10, 32'h0000_0011, 4'b0001);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (core_req_valid && core_req_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("rmw_accept", 128'(got), 128'(1));
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    push(0, 1'b0, 32'h10, 32'h0, 4'h0);
    push(1, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_idle();

    // Empty store on core racing a dbg load.
    do_reset();
    push(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0);
    push(1, 1'b0, 32'h20, 32'h0, 4'h0);
    wait_idle();

    rand_en = 1'b1;
    repeat (3000) @(posedge clk);
    rand_en = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk);
    check("leftover", 128'(exp_core.size() + exp_dbg.size()), 128'(0));
    nmis = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) nmis++;
    check("memimg", 128'(nmis), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
